// File: rtl/tick_sequencer.sv
// rtl/tick_sequencer.sv - paced, counted tick scheduler driving an odd-ticks toggle bit
// Optional feature macro: TICK_SEQUENCER_ABORT_EN (adds i_abort to cut a run short)
module tick_sequencer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic [CNT_W-1:0] i_period,
  input  logic [CNT_W-1:0] i_count,
`ifdef TICK_SEQUENCER_ABORT_EN
  input  logic             i_abort,
`endif
  output logic             o_tick,
  output logic             o_data,
  output logic             o_busy,
  output logic             o_done,
  output logic [CNT_W-1:0] o_left
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] ZERO = '0;

  state_t           state, state_n;
  logic [CNT_W-1:0] per, per_n;
  logic [CNT_W-1:0] div, div_n;
  logic [CNT_W-1:0] left, left_n;
  logic             r_data, data_n;
  logic             tick;
  logic             done;
  logic             abort;

  // Abort only exists in the optional build; otherwise it is tied off so runs always complete.
`ifdef TICK_SEQUENCER_ABORT_EN
  assign abort = i_abort;
`else
  assign abort = 1'b0;
`endif

  // State and datapath registers; reset returns everything, including the toggle bit, to zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      per    <= ZERO;
      div    <= ZERO;
      left   <= ZERO;
      r_data <= 1'b0;
    end else begin
      state  <= state_n;
      per    <= per_n;
      div    <= div_n;
      left   <= left_n;
      r_data <= data_n;
    end
  end

  // Next-state and datapath decisions; a tick fires whenever the divider has run down to zero.
  always_comb begin
    state_n = state;
    per_n   = per;
    div_n   = div;
    left_n  = left;
    data_n  = r_data;
    tick    = 1'b0;
    done    = 1'b0;
    case (state)
      S_IDLE: begin
        if (i_start) begin
          per_n  = i_period;
          left_n = i_count;
          if (i_count != ZERO) begin
            div_n   = i_period;
            state_n = S_RUN;
          end else begin
            // Zero-length run: report completion straight away with no tick.
            state_n = S_DONE;
          end
        end
      end
      S_RUN: begin
        if (abort) begin
          // Abort outranks a pending tick; remaining count stays visible on o_left.
          state_n = S_DONE;
        end else if (div == ZERO) begin
          tick   = 1'b1;
          data_n = ~r_data;
          left_n = left - ONE;
          div_n  = per;
          if (left == ONE) begin
            state_n = S_DONE;
          end
        end else begin
          div_n = div - ONE;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  assign o_tick = tick;
  assign o_done = done;
  assign o_busy = (state != S_IDLE);
  assign o_data = r_data;
  assign o_left = left;

endmodule

// File: tb/tb_tick_sequencer.sv
// tb/tb_tick_sequencer.sv - scoreboard bench for tick_sequencer with randomized runs
module tb_tick_sequencer;

  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             i_start = 1'b0;
  logic [CNT_W-1:0] i_period = '0;
  logic [CNT_W-1:0] i_count = '0;
`ifdef TICK_SEQUENCER_ABORT_EN
  logic             i_abort = 1'b0;
`endif
  logic             o_tick;
  logic             o_data;
  logic             o_busy;
  logic             o_done;
  logic [CNT_W-1:0] o_left;

  tick_sequencer #(.CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .i_start  (i_start),
    .i_period (i_period),
    .i_count  (i_count),
`ifdef TICK_SEQUENCER_ABORT_EN
    .i_abort  (i_abort),
`endif
    .o_tick   (o_tick),
    .o_data   (o_data),
    .o_busy   (o_busy),
    .o_done   (o_done),
    .o_left   (o_left)
  );

  always #5 clk = ~clk;

  // Cycle index: during cycle k (after posedge k) the negedge sees cyc == k.
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned cyc;
    bit          is_done;
    bit          data;
    int unsigned left;
  } ev_t;

  ev_t         exp_q[$];
  ev_t         mon_e;
  int          n_checks = 0;
  int          n_fail = 0;
  int unsigned busy_cnt = 0;
  bit          model_data = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push_ev(input int unsigned c, input bit is_done, input bit d, input int unsigned l);
    ev_t e;
    e.cyc = c;
    e.is_done = is_done;
    e.data = d;
    e.left = l;
    exp_q.push_back(e);
  endtask

  // Monitor: every tick or done the DUT presents is matched against the next expected event.
  always @(negedge clk) begin
    if (o_busy === 1'b1) busy_cnt++;
    if (cyc != 0 && (o_tick !== 1'b0 || o_done !== 1'b0)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", {30'd0, o_tick, o_done}, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("event_cycle", cyc, mon_e.cyc);
        check("event_done", {31'd0, o_done}, {31'd0, mon_e.is_done});
        check("event_tick", {31'd0, o_tick}, {31'd0, !mon_e.is_done});
        check("event_data", {31'd0, o_data}, {31'd0, mon_e.data});
        check("event_left", {24'd0, o_left}, mon_e.left);
      end
    end
  end

  // One complete run: expected ticks follow k+(i-1)(P+1)+P, done follows the last tick.
  task automatic run_seq(input int unsigned p, input int unsigned n, input bit poke);
    int unsigned k;
    int unsigned done_c;
    int unsigned b0;
    int unsigned exp_busy;
    @(negedge clk);
    i_start  = 1'b1;
    i_period = CNT_W'(p);
    i_count  = CNT_W'(n);
    k = cyc + 1;
    for (int i = 1; i <= int'(n); i++) begin
      push_ev(k + (i - 1) * (p + 1) + p, 1'b0, model_data ^ bit'((i - 1) % 2), n - (i - 1));
    end
    done_c = k + n * (p + 1);
    model_data = model_data ^ bit'(n % 2);
    push_ev(done_c, 1'b1, model_data, 0);
    exp_busy = (n == 0) ? 1 : n * (p + 1) + 1;
    b0 = busy_cnt;
    @(negedge clk);
    i_start  = 1'b0;
    i_period = CNT_W'($urandom);
    i_count  = CNT_W'($urandom);
    while (cyc <= done_c) begin
      i_start = poke && ($urandom_range(0, 3) == 0 || cyc == done_c);
      @(negedge clk);
    end
    i_start = 1'b0;
    check("busy_low_after_done", {31'd0, o_busy}, 32'd0);
    check("busy_cycles", busy_cnt - b0, exp_busy);
    check("events_drained", exp_q.size(), 32'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    check("no_second_run", {31'd0, o_busy}, 32'd0);
  endtask

  initial begin
    int unsigned k;
    int unsigned p;
    int unsigned n;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_tick", {31'd0, o_tick}, 32'd0);
    check("reset_data", {31'd0, o_data}, 32'd0);
    check("reset_busy", {31'd0, o_busy}, 32'd0);
    check("reset_done", {31'd0, o_done}, 32'd0);
    check("reset_left", {24'd0, o_left}, 32'd0);
    rst = 1'b0;
    model_data = 1'b0;

    run_seq(0, 3, 1'b0);
    run_seq(2, 2, 1'b0);
    run_seq(5, 0, 1'b0);
    run_seq(1, 3, 1'b1);
    run_seq(3, 0, 1'b1);

    // Reset after the first tick of an N=4 run: everything clears, no done appears.
    p = $urandom_range(0, 3);
    @(negedge clk);
    i_start  = 1'b1;
    i_period = CNT_W'(p);
    i_count  = CNT_W'(4);
    k = cyc + 1;
    push_ev(k + p, 1'b0, model_data, 4);
    @(negedge clk);
    i_start = 1'b0;
    while (cyc < k + p) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrun_reset_tick", {31'd0, o_tick}, 32'd0);
    check("midrun_reset_data", {31'd0, o_data}, 32'd0);
    check("midrun_reset_busy", {31'd0, o_busy}, 32'd0);
    check("midrun_reset_done", {31'd0, o_done}, 32'd0);
    check("midrun_reset_left", {24'd0, o_left}, 32'd0);
    rst = 1'b0;
    model_data = 1'b0;
    check("midrun_first_tick_seen", exp_q.size(), 32'd0);
    exp_q.delete();
    repeat (4) @(negedge clk);
    run_seq(2, 4, 1'b0);

    // Boundary runs: maximum period and maximum count.
    run_seq(255, 2, 1'b0);
    run_seq(0, 255, 1'b1);

    for (int it = 0; it < 25; it++) begin
      p = ($urandom_range(0, 9) == 0) ? 255 : $urandom_range(0, 4);
      n = $urandom_range(0, 6);
      run_seq(p, n, bit'($urandom_range(0, 1)));
    end

`ifdef TICK_SEQUENCER_ABORT_EN
    // Abort on what would be the third tick of a P=1, N=5 run.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_data = 1'b0;
    @(negedge clk);
    i_start  = 1'b1;
    i_period = CNT_W'(1);
    i_count  = CNT_W'(5);
    k = cyc + 1;
    push_ev(k + 1, 1'b0, 1'b0, 5);
    push_ev(k + 3, 1'b0, 1'b1, 4);
    push_ev(k + 6, 1'b1, 1'b0, 3);
    n = busy_cnt;
    @(negedge clk);
    i_start = 1'b0;
    while (cyc <= k + 6) begin
      i_abort = (cyc == k + 5);
      @(negedge clk);
    end
    i_abort = 1'b0;
    check("abort_busy_cycles", busy_cnt - n, 32'd7);
    check("abort_events_drained", exp_q.size(), 32'd0);
    check("abort_data", {31'd0, o_data}, 32'd0);
    exp_q.delete();
    run_seq(1, 2, 1'b0);
`endif

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
